// File: rtl/vram_arbiter.sv
// Single-port video-RAM arbiter: display scanout vs CPU write/read, blank-aware priority.
// Latency: grant/command in the cycle after the request edge; read data valid two cycles after grant.
// Backpressure: requesters hold until granted; optional starvation guard via VRAM_ARB_STARVE_GUARD_EN.
module vram_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 8,
  parameter int MAX_DISP_RUN = 4
) (
  input  logic              CLOCK_50,
  input  logic              RST_N,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic              disp_blank,
  output logic              disp_gnt,
  output logic              disp_rd_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              cpu_wr_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_rd_req,
  output logic              cpu_wr_gnt,
  output logic              cpu_rd_gnt,
  output logic              cpu_rd_valid,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, DISP, CPU_WR, CPU_RD} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_mem_we;
  logic                r_mem_re;
  logic                r_p1_vld;
  logic                r_p1_cpu;
  logic                r_disp_vld;
  logic                r_cpu_vld;
  logic [DATA_W-1:0]   r_disp_data;
  logic [DATA_W-1:0]   r_cpu_data;
  logic                w_cpu_pend;
  logic                w_force_cpu;

  assign w_cpu_pend = cpu_wr_req | cpu_rd_req;

`ifdef VRAM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(MAX_DISP_RUN + 1);
  logic [CNT_W-1:0] r_run_cnt;

  assign w_force_cpu = w_cpu_pend && (r_run_cnt == CNT_W'(MAX_DISP_RUN));

  // Count display grants issued while the CPU is kept waiting
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      r_run_cnt <= '0;
    end else if (w_state_nxt == DISP && w_cpu_pend) begin
      r_run_cnt <= r_run_cnt + 1'b1;
    end else begin
      r_run_cnt <= '0;
    end
  end
`else
  // Without the guard the CPU is never forced in; the run length is irrelevant
  assign w_force_cpu = (MAX_DISP_RUN < 0);
`endif

  // Next owner: blank-dependent priority, overridden by the starvation guard
  always_comb begin
    w_state_nxt = IDLE;
    if (w_force_cpu) begin
      w_state_nxt = cpu_wr_req ? CPU_WR : CPU_RD;
    end else if (!disp_blank) begin
      if (disp_req)        w_state_nxt = DISP;
      else if (cpu_wr_req) w_state_nxt = CPU_WR;
      else if (cpu_rd_req) w_state_nxt = CPU_RD;
    end else begin
      if (cpu_wr_req)      w_state_nxt = CPU_WR;
      else if (cpu_rd_req) w_state_nxt = CPU_RD;
      else if (disp_req)   w_state_nxt = DISP;
    end
  end

  // State register and registered RAM command for the chosen owner
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= IDLE;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (w_state_nxt)
        DISP: begin
          r_mem_addr <= disp_addr;
          r_mem_re   <= 1'b1;
          r_mem_we   <= 1'b0;
        end
        CPU_RD: begin
          r_mem_addr <= cpu_addr;
          r_mem_re   <= 1'b1;
          r_mem_we   <= 1'b0;
        end
        CPU_WR: begin
          r_mem_addr  <= cpu_addr;
          r_mem_wdata <= cpu_wdata;
          r_mem_we    <= 1'b1;
          r_mem_re    <= 1'b0;
        end
        default: begin
          r_mem_we <= 1'b0;
          r_mem_re <= 1'b0;
        end
      endcase
    end
  end

  // Read return: tag travels with the read, data captured the cycle after the RAM answers
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      r_p1_vld    <= 1'b0;
      r_p1_cpu    <= 1'b0;
      r_disp_vld  <= 1'b0;
      r_cpu_vld   <= 1'b0;
      r_disp_data <= '0;
      r_cpu_data  <= '0;
    end else begin
      r_p1_vld   <= r_mem_re;
      r_p1_cpu   <= (r_state == CPU_RD);
      r_disp_vld <= r_p1_vld & ~r_p1_cpu;
      r_cpu_vld  <= r_p1_vld & r_p1_cpu;
      if (r_p1_vld && !r_p1_cpu) r_disp_data <= mem_rdata;
      if (r_p1_vld && r_p1_cpu)  r_cpu_data  <= mem_rdata;
    end
  end

  assign disp_gnt      = (r_state == DISP);
  assign cpu_wr_gnt    = (r_state == CPU_WR);
  assign cpu_rd_gnt    = (r_state == CPU_RD);
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign mem_we        = r_mem_we;
  assign mem_re        = r_mem_re;
  assign disp_rd_valid = r_disp_vld;
  assign disp_data     = r_disp_data;
  assign cpu_rd_valid  = r_cpu_vld;
  assign cpu_rd_data   = r_cpu_data;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios, a transaction-level model and a per-cycle compare.
module tb_vram_arbiter;
  localparam int AW   = 19;
  localparam int DW   = 8;
  localparam int MAXR = 4;

  logic          CLOCK_50 = 1'b0;
  logic          RST_N;
  logic          disp_req, disp_blank, cpu_wr_req, cpu_rd_req;
  logic [AW-1:0] disp_addr, cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          disp_gnt, disp_rd_valid, cpu_wr_gnt, cpu_rd_gnt, cpu_rd_valid;
  logic [DW-1:0] disp_data, cpu_rd_data, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we, mem_re;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DISP_RUN(MAXR)) dut (
    .CLOCK_50(CLOCK_50), .RST_N(RST_N),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_blank(disp_blank),
    .disp_gnt(disp_gnt), .disp_rd_valid(disp_rd_valid), .disp_data(disp_data),
    .cpu_wr_req(cpu_wr_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rd_req(cpu_rd_req), .cpu_wr_gnt(cpu_wr_gnt), .cpu_rd_gnt(cpu_rd_gnt),
    .cpu_rd_valid(cpu_rd_valid), .cpu_rd_data(cpu_rd_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Synchronous single-port RAM: read data one cycle after mem_re
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge CLOCK_50) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct { int unsigned cyc; bit cpu; logic [DW-1:0] data; } ret_t;
  ret_t          ret_q[$];
  logic [DW-1:0] model_mem [0:(1<<AW)-1];
  int unsigned   m_cyc = 0;
  int            m_gnt = 0;   // 0 none, 1 display, 2 cpu write, 3 cpu read
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_disp_data = '0, m_cpu_data = '0;
  bit            m_disp_vld = 0, m_cpu_vld = 0;
`ifdef VRAM_ARB_STARVE_GUARD_EN
  int            m_run = 0;
`endif

  always @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      m_cyc = 0; m_gnt = 0; m_addr = '0; m_wdata = '0;
      m_disp_data = '0; m_cpu_data = '0; m_disp_vld = 0; m_cpu_vld = 0;
      ret_q.delete();
`ifdef VRAM_ARB_STARVE_GUARD_EN
      m_run = 0;
`endif
    end else begin
      bit pend, force_cpu;
      int g;
      m_cyc++;
      pend = cpu_wr_req || cpu_rd_req;
      force_cpu = 0;
`ifdef VRAM_ARB_STARVE_GUARD_EN
      force_cpu = pend && (m_run == MAXR);
`endif
      if (force_cpu)        g = cpu_wr_req ? 2 : 3;
      else if (!disp_blank) g = disp_req ? 1 : cpu_wr_req ? 2 : cpu_rd_req ? 3 : 0;
      else                  g = cpu_wr_req ? 2 : cpu_rd_req ? 3 : disp_req ? 1 : 0;
`ifdef VRAM_ARB_STARVE_GUARD_EN
      m_run = (g == 1 && pend) ? m_run + 1 : 0;
`endif
      m_gnt = g;
      m_disp_vld = 0; m_cpu_vld = 0;
      if (ret_q.size() > 0 && ret_q[0].cyc == m_cyc) begin
        ret_t r;
        r = ret_q.pop_front();
        if (r.cpu) begin m_cpu_vld = 1; m_cpu_data = r.data; end
        else begin m_disp_vld = 1; m_disp_data = r.data; end
      end
      if (g == 1) begin
        m_addr = disp_addr;
        ret_q.push_back('{m_cyc + 2, 1'b0, model_mem[disp_addr]});
      end else if (g == 3) begin
        m_addr = cpu_addr;
        ret_q.push_back('{m_cyc + 2, 1'b1, model_mem[cpu_addr]});
      end else if (g == 2) begin
        m_addr = cpu_addr;
        m_wdata = cpu_wdata;
        model_mem[cpu_addr] = cpu_wdata;
      end
    end
  end

  // Per-cycle compare of every output against the model
  always @(negedge CLOCK_50) begin
    if (chk_on) begin
      chk("disp_gnt",      {31'd0, disp_gnt},      {31'd0, m_gnt == 1});
      chk("cpu_wr_gnt",    {31'd0, cpu_wr_gnt},    {31'd0, m_gnt == 2});
      chk("cpu_rd_gnt",    {31'd0, cpu_rd_gnt},    {31'd0, m_gnt == 3});
      chk("mem_we",        {31'd0, mem_we},        {31'd0, m_gnt == 2});
      chk("mem_re",        {31'd0, mem_re},        {31'd0, m_gnt == 1 || m_gnt == 3});
      chk("mem_addr",      32'(mem_addr),          32'(m_addr));
      chk("mem_wdata",     32'(mem_wdata),         32'(m_wdata));
      chk("disp_rd_valid", {31'd0, disp_rd_valid}, {31'd0, m_disp_vld});
      chk("cpu_rd_valid",  {31'd0, cpu_rd_valid},  {31'd0, m_cpu_vld});
      chk("disp_data",     32'(disp_data),         32'(m_disp_data));
      chk("cpu_rd_data",   32'(cpu_rd_data),       32'(m_cpu_data));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge CLOCK_50);
    #2;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ram[a] = d;
    model_mem[a] = d;
  endtask

  function automatic int gcode();
    return disp_gnt ? 1 : cpu_wr_gnt ? 2 : cpu_rd_gnt ? 3 : 0;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnts"}, {29'd0, disp_gnt, cpu_wr_gnt, cpu_rd_gnt}, 32'd0);
    chk({tag, "_mem_cmd"}, {30'd0, mem_we, mem_re}, 32'd0);
    chk({tag, "_valids"}, {30'd0, disp_rd_valid, cpu_rd_valid}, 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_rdata"}, {16'd0, disp_data, cpu_rd_data}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq[3];
    int nd, nc, exp_g;
    RST_N = 1'b0;
    disp_req = 0; disp_blank = 0; cpu_wr_req = 0; cpu_rd_req = 0;
    disp_addr = '0; cpu_addr = '0; cpu_wdata = '0;
    preload(19'h00010, 8'hA5);
    for (int i = 0; i < 3; i++) preload(19'h00020 + 19'(i), 8'h40 + 8'(i));
    for (int i = 0; i < 3; i++) preload(19'h00300 + 19'(i), 8'h80 + 8'(i));
    #1 chk_on = 1;

    // Reset state, then first display read
    step(); step();
    chk_all_zero("reset");
    disp_req = 1; disp_addr = 19'h00010;
    step();
    chk("no_gnt_in_reset", {31'd0, disp_gnt}, 32'd0);
    RST_N = 1'b1;
    step();                                     // cycle 1
    chk("first_disp_gnt", {31'd0, disp_gnt}, 32'd1);
    disp_req = 0;
    step();                                     // cycle 2
    chk("first_vld_early", {31'd0, disp_rd_valid}, 32'd0);
    step();                                     // cycle 3
    chk("first_vld", {31'd0, disp_rd_valid}, 32'd1);
    chk("first_data", 32'(disp_data), 32'hA5);
    step();

    // Blanking priority; write then read of the same address
    disp_blank = 1; cpu_addr = 19'h00100; cpu_wdata = 8'h3C; disp_addr = 19'h00010;
    disp_req = 1; cpu_wr_req = 1; cpu_rd_req = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      seq[i] = gcode();
      if (disp_gnt)   disp_req = 0;
      if (cpu_wr_gnt) cpu_wr_req = 0;
      if (cpu_rd_gnt) cpu_rd_req = 0;
    end
    chk("blank_order0", 32'(seq[0]), 32'd2);
    chk("blank_order1", 32'(seq[1]), 32'd3);
    chk("blank_order2", 32'(seq[2]), 32'd1);
    step();
    chk("wr_rd_vld", {31'd0, cpu_rd_valid}, 32'd1);
    chk("wr_rd_data", 32'(cpu_rd_data), 32'h3C);
    step();
    chk("blank_disp_data", 32'(disp_data), 32'hA5);
    disp_blank = 0;
    step();

    // Alternating display / CPU reads back-to-back
    nd = 0; nc = 0;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin disp_req = 1; disp_addr = 19'h00020 + 19'(i / 2); end
      else begin cpu_rd_req = 1; cpu_addr = 19'h00300 + 19'(i / 2); end
      step();
      chk("alt_gnt", 32'(gcode()), (i % 2 == 0) ? 32'd1 : 32'd3);
      nd += int'(disp_rd_valid); nc += int'(cpu_rd_valid);
      disp_req = 0; cpu_rd_req = 0;
    end
    for (int i = 0; i < 2; i++) begin
      step();
      nd += int'(disp_rd_valid); nc += int'(cpu_rd_valid);
    end
    chk("alt_disp_count", 32'(nd), 32'd3);
    chk("alt_cpu_count", 32'(nc), 32'd3);
    chk("alt_last_cpu_data", 32'(cpu_rd_data), 32'h82);
    chk("alt_last_disp_data", 32'(disp_data), 32'h42);
    step();

    // Active video with display and CPU write held continuously
    disp_addr = 19'h00010; cpu_addr = 19'h00400;
    disp_req = 1; cpu_wr_req = 1;
    for (int i = 0; i < 15; i++) begin
      cpu_wdata = 8'(i);
`ifdef VRAM_ARB_STARVE_GUARD_EN
      exp_g = (i % 5 == 4) ? 2 : 1;
`else
      exp_g = 1;
`endif
      step();
      chk("starve_pattern", 32'(gcode()), 32'(exp_g));
    end
    disp_req = 0; cpu_wr_req = 0;
    repeat (4) step();

    // Reset while a display read is in flight
    disp_req = 1; disp_addr = 19'h00010;
    step();
    chk("inflight_gnt", {31'd0, disp_gnt}, 32'd1);
    disp_req = 0;
    step();
    RST_N = 1'b0;
    #1;
    chk_all_zero("async_rst");
    step(); step();
    RST_N = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("no_stale_vld", {31'd0, disp_rd_valid}, 32'd0);
    end

    chk_on = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
